vic1_microsequencer: RTL
========================

# vic1_microsequencer

Control-store sequencer for the Vic1 microarchitecture. It owns the microprogram counter (MPC) and the microinstruction register (MIR). Each cycle it computes the next control-store address from the current MIR's NEXT_ADDRESS and JAM fields, the live ALU N/Z outputs and the MBR byte, and loads the addressed word into MIR. It sits directly upstream of the datapath: the datapath consumes `mir` and returns `alu_n`, `alu_z` and `mbr`.

## Interface
- `ADDR_W`, 10: MPC / NEXT_ADDRESS width.
- `MIR_W`, 37: microinstruction width.
- `JAM_BIT`, 8: MPC bit that JAMN/JAMZ OR in (weight 0x100).
- `RESET_ADDR`, 0: MPC value after reset.
- `HALT_ADDR`, 10'h3FF: when MPC reaches this address, the sequencer freezes.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `cs_addr` out ADDR_W: control-store read address; equals the next-MPC value computed this cycle.
- `cs_data` in MIR_W: control-store word; asynchronous read of `cs_addr`.
- `alu_n` in 1: ALU negative output for the current `mir`.
- `alu_z` in 1: ALU zero output for the current `mir`.
- `mbr` in 8: MBR contents, unsigned.
- `mem_wait` in 1: memory busy; stalls sequencing.
- `mir` out MIR_W: current microinstruction to the datapath.
- `mpc` out ADDR_W: address of the current `mir`.
- `n_flag` out 1: registered N flag.
- `z_flag` out 1: registered Z flag.
- `halted` out 1: sequencer is frozen at HALT_ADDR.
- `ucycles` out 32: count of retired microinstructions; saturates.

## Operation
- MIR fields, MSB first:
  - NEXT_ADDRESS [36:27]
  - JAM [26:24] = {JMPC, JAMN, JAMZ}
  - ALU [23:16]
  - C [15:7]
  - MEM [6:4] = {write, read, fetch}
  - B [3:0]
- Next-MPC calculation, where `na` is NEXT_ADDRESS:
  - Start from `na`.
  - If JAMN and `alu_n`, set bit JAM_BIT.
  - If JAMZ and `alu_z`, set bit JAM_BIT.
  - If JMPC, OR `{2'b0, mbr}` into the low 8 bits.
  - All rules apply together (bitwise OR). Addresses never wrap or carry.
- `cs_addr` = next-MPC. It is purely combinational from `mir`, `alu_n`, `alu_z` and `mbr`.
- Advance edge (reset high, `mem_wait`=0, `halted`=0):
  - `mpc` <= `cs_addr`
  - `mir` <= `cs_data`
  - `n_flag` <= `alu_n`, `z_flag` <= `alu_z`
  - `ucycles` increments, saturating at 32'hFFFF_FFFF.
- Stall edge (`mem_wait`=1): all registers hold. The datapath sees the same `mir` again.
- Halt: on an advance edge that loads `mpc` == HALT_ADDR, `halted` goes to 1 on that same edge.
  - That MIR is still presented to the datapath.
  - All registers, including `ucycles`, then hold until reset.
  - `mem_wait` is ignored while halted.
- States:
  - RUN → STALL when `mem_wait`=1; STALL → RUN when `mem_wait`=0.
  - RUN → HALT when the loaded address equals HALT_ADDR.
  - HALT is left only by reset.
  - A stall and a halt load cannot coincide, because a stall holds MPC.

## Timing
- Reset (asynchronous assert, any time, including mid-stall or while halted):
  - `mpc` = RESET_ADDR, `mir` = 0 (all enables off, no memory op)
  - `n_flag` = `z_flag` = 0, `halted` = 0, `ucycles` = 0
- First edge after release:
  - `mir` = 0 gives next-MPC = 0, so `mpc` <= 0 and `mir` <= store[0].
  - The reset MIR is therefore one dead cycle.
  - `ucycles` = 1 after this edge.
- Latency: exactly one cycle from a MIR being presented to its successor being presented. There is no bubble on jumps.
- `alu_n`, `alu_z` and `mbr` must be stable before the edge. They are sampled on the same edge that loads the successor.
- `mem_wait` is sampled at the edge. A one-cycle pulse repeats the current `mir` for exactly one extra cycle.

## Structure
- Package `vic1_pkg` holds:
  - the `mir_t` packed struct with the field layout above
  - the JAM bit-index constants
  - ADDR_W and MIR_W defaults
  - RESET_ADDR and HALT_ADDR defaults
- One combinational sub-module, `vic1_next_addr`:
  - inputs: `na`, `jam`, `alu_n`, `alu_z`, `mbr`
  - output: next-MPC
- The run/stall/halt control and the registers live in the top module.

## Test plan
- Reset, then release with store[0] = {na=5, jam=0}:
  - `mpc`=0 and `mir`=0 during reset.
  - Edge 1: `mpc`=0, `mir`=store[0].
  - Edge 2: `mpc`=5.
- JMPC with na=0, `mbr`=8'h10 → next `mpc`=10'h010. Then `mbr`=8'hA7 → next `mpc`=10'h0A7.
- JAMZ with na=0x12:
  - `alu_z`=1 → `mpc`=0x112, `z_flag`=1.
  - `alu_z`=0 → `mpc`=0x012.
  - JAMN with `alu_n`=1 and na=0x100 → `mpc` stays 0x100 (already set; no carry).
- `mem_wait` high for 3 cycles mid-program → `mpc`, `mir` and `ucycles` unchanged for 3 edges, then resume with the correct successor.
- A program jumping to 0x3FF:
  - `halted`=1 on the load edge.
  - `mpc` stays 0x3FF and `ucycles` stays frozen for 10 further cycles.
  - Reset then clears everything.
- Assert reset asynchronously mid-cycle during a stall → outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vic1_pkg.sv
// Shared types and defaults for the Vic1 microsequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vic1_pkg;

  localparam int              ADDR_W_DEF     = 10;
  localparam int              MIR_W_DEF      = 37;
  localparam int              JAM_BIT_DEF    = 8;
  localparam logic [9:0]      RESET_ADDR_DEF = 10'h000;
  localparam logic [9:0]      HALT_ADDR_DEF  = 10'h3FF;

  // Bit positions inside the 3-bit JAM field {JMPC, JAMN, JAMZ}
  localparam int JAM_JMPC = 2;
  localparam int JAM_JAMN = 1;
  localparam int JAM_JAMZ = 0;

  // Microinstruction layout, MSB first (37 bits total)
  typedef struct packed {
    logic [9:0] next_address;  // [36:27]
    logic [2:0] jam;           // [26:24] {JMPC, JAMN, JAMZ}
    logic [7:0] alu;           // [23:16]
    logic [8:0] c;             // [15:7]
    logic [2:0] mem;           // [6:4]  {write, read, fetch}
    logic [3:0] b;             // [3:0]
  } mir_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/vic1_next_addr.sv
// Next control-store address from NEXT_ADDRESS, JAM bits, ALU flags and MBR.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is loaded.
// Ports: na/jam from the current MIR, alu_n/alu_z/mbr from the datapath,
//        next_addr is the OR-combined successor address.
import vic1_pkg::*;

module vic1_next_addr #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int JAM_BIT = JAM_BIT_DEF
) (
  input  logic [ADDR_W-1:0] na,
  input  logic [2:0]        jam,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic [7:0]        mbr,
  output logic [ADDR_W-1:0] next_addr
);

  // All modifiers are ORed in, so a bit already set in na stays set and
  // nothing ever carries into higher bits.
  always_comb begin
    next_addr = na;
    if ((jam[JAM_JAMN] && alu_n) || (jam[JAM_JAMZ] && alu_z)) begin
      next_addr[JAM_BIT] = 1'b1;
    end
    if (jam[JAM_JMPC]) begin
      next_addr = next_addr | ADDR_W'(mbr);
    end
  end

endmodule

// File: rtl/vic1_microsequencer.sv
// Vic1 microsequencer: owns MPC/MIR, computes next address, loads control store.
// Latency: one cycle from a MIR being presented to its successor; no bubble on jumps.
// Backpressure: mem_wait holds every register; once HALT_ADDR is loaded all state freezes until reset.
// Ports: clock/reset (async active-low); cs_addr/cs_data async control-store read;
//        alu_n/alu_z/mbr/mem_wait from datapath; mir/mpc/n_flag/z_flag/halted/ucycles out.
import vic1_pkg::*;

module vic1_microsequencer #(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                MIR_W      = MIR_W_DEF,
  parameter int                JAM_BIT    = JAM_BIT_DEF,
  parameter logic [ADDR_W-1:0] RESET_ADDR = RESET_ADDR_DEF,
  parameter logic [ADDR_W-1:0] HALT_ADDR  = HALT_ADDR_DEF
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] cs_addr,
  input  logic [MIR_W-1:0]  cs_data,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic [7:0]        mbr,
  input  logic              mem_wait,
  output logic [MIR_W-1:0]  mir,
  output logic [ADDR_W-1:0] mpc,
  output logic              n_flag,
  output logic              z_flag,
  output logic              halted,
  output logic [31:0]       ucycles
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mpc_q, mpc_d;
  logic [MIR_W-1:0]  mir_q, mir_d;
  logic              n_flag_q, n_flag_d;
  logic              z_flag_q, z_flag_d;
  logic [31:0]       ucycles_q, ucycles_d;
  logic              advance;
  mir_t              mir_f;

  assign mir_f = mir_q;

  vic1_next_addr #(
    .ADDR_W  (ADDR_W),
    .JAM_BIT (JAM_BIT)
  ) u_next_addr (
    .na        (mir_f.next_address),
    .jam       (mir_f.jam),
    .alu_n     (alu_n),
    .alu_z     (alu_z),
    .mbr       (mbr),
    .next_addr (cs_addr)
  );

  // STALL only records that the last edge was held; advancing is decided
  // purely by mem_wait, so RUN and STALL behave identically on each edge.
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (mem_wait) begin
          state_d = ST_STALL;
        end else begin
          advance = 1'b1;
          state_d = (cs_addr == HALT_ADDR) ? ST_HALT : ST_RUN;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    mpc_d     = mpc_q;
    mir_d     = mir_q;
    n_flag_d  = n_flag_q;
    z_flag_d  = z_flag_q;
    ucycles_d = ucycles_q;
    if (advance) begin
      mpc_d    = cs_addr;
      mir_d    = cs_data;
      n_flag_d = alu_n;
      z_flag_d = alu_z;
      if (ucycles_q != 32'hFFFF_FFFF) begin
        ucycles_d = ucycles_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      mpc_q     <= RESET_ADDR;
      mir_q     <= '0;
      n_flag_q  <= 1'b0;
      z_flag_q  <= 1'b0;
      ucycles_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      mpc_q     <= mpc_d;
      mir_q     <= mir_d;
      n_flag_q  <= n_flag_d;
      z_flag_q  <= z_flag_d;
      ucycles_q <= ucycles_d;
    end
  end

  assign mir     = mir_q;
  assign mpc     = mpc_q;
  assign n_flag  = n_flag_q;
  assign z_flag  = z_flag_q;
  assign halted  = (state_q == ST_HALT);
  assign ucycles = ucycles_q;

endmodule
